// File: rtl/wieg_pkg.sv
// rtl/wieg_pkg.sv - shared types, limits and encodings for the cradle drive
//
// Purpose: FSM state type, setting bounds, keuze/stap encodings and the
//          bound test used by the hill-climbing step.
// Ports:   none (package).
package wieg_pkg;

  typedef enum logic [1:0] {
    UIT   = 2'd0,
    WACHT = 2'd1,
    EVAL  = 2'd2
  } toestand_t;

  localparam logic [2:0] AMP_MIN  = 3'd1;
  localparam logic [2:0] AMP_MAX  = 3'd7;
  localparam logic [2:0] FREQ_MIN = 3'd0;
  localparam logic [2:0] FREQ_MAX = 3'd7;

  // keuze: which setting the climber is currently adjusting
  localparam logic KEUZE_AMP  = 1'b0;
  localparam logic KEUZE_FREQ = 1'b1;

  // stap: direction of the next step
  localparam logic STAP_UP   = 1'b0;
  localparam logic STAP_DOWN = 1'b1;

  // True when a step in direction dir would leave the range lo..hi.
  function automatic logic step_blocked(input logic [2:0] val,
                                        input logic [2:0] lo,
                                        input logic [2:0] hi,
                                        input logic       dir);
    return (dir == STAP_UP) ? (val == hi) : (val == lo);
  endfunction

endpackage

// File: rtl/wieg_pwm.sv
// rtl/wieg_pwm.sv - swing direction timing and PWM motor drive for the H-bridge
//
// Purpose: half-period counter that alternates the swing direction, and a
//          3-bit PWM slot counter that gates the drive by amplitude.
// Ports:   clk, reset (sync, active-low)
//          enable      - drive allowed (rocking on and FSM not in UIT)
//          amplitude   - PWM on-slots out of 8
//          frequentie  - half-swing length is HALF_BASE*(8-frequentie) clk
//          motorLinks  - left drive
//          motorRechts - right drive
module wieg_pwm #(
  parameter int HALF_BASE = 4000000,
  parameter int PWM_DIV   = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] amplitude,
  input  logic [2:0] frequentie,
  output logic       motorLinks,
  output logic       motorRechts
);

  localparam int HW  = $clog2(HALF_BASE * 8);
  localparam int PDW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  localparam logic [HW-1:0]  HB       = HW'(HALF_BASE);
  localparam logic [PDW-1:0] DIV_LAST = PDW'(PWM_DIV - 1);

  logic [HW-1:0]  half_cnt;
  logic [HW-1:0]  half_mult;
  logic [HW-1:0]  reload;
  logic [PDW-1:0] div_cnt;
  logic [2:0]     slot;
  logic           dir_left;
  logic           pwm_on;

  // HALF_BASE*(8-f)-1; when HALF_BASE*8 is a power of two the product wraps to
  // zero for f=0 and the subtraction brings it back to the correct all-ones value.
  assign half_mult = HW'(4'd8 - {1'b0, frequentie});
  assign reload    = (HB * half_mult) - HW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      half_cnt <= reload;
      dir_left <= 1'b1;
      div_cnt  <= '0;
      slot     <= '0;
    end else begin
      // frequentie is only picked up here, so a change waits for the next swing
      if (half_cnt == '0) begin
        half_cnt <= reload;
        dir_left <= ~dir_left;
      end else begin
        half_cnt <= half_cnt - HW'(1);
      end

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        slot    <= slot + 3'd1;
      end else begin
        div_cnt <= div_cnt + PDW'(1);
      end
    end
  end

  assign pwm_on      = (slot < amplitude);
  assign motorLinks  = enable & dir_left & pwm_on;
  assign motorRechts = enable & ~dir_left & pwm_on;

  // Shoot-through guard for the H-bridge.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(motorLinks && motorRechts));
    end
  end

endmodule

// File: rtl/wieg_aansturing.sv
// rtl/wieg_aansturing.sv - hill-climbing cradle control with H-bridge drive
//
// Purpose: once per slowClk rising edge evaluates the stress-trend flags and
//          steps amplitude or frequentie towards lower stress, then drives
//          the motor through wieg_pwm.
// Ports:   clk, reset (sync, active-low)
//          slowClk      - evaluation tick (rising edge used)
//          aan          - rocking enable
//          stressLaag   - stress went down
//          stressGelijk - stress unchanged
//          amplitude, frequentie - current settings
//          motorLinks, motorRechts - H-bridge drive
//          toestand     - FSM state (debug)
module wieg_aansturing
  import wieg_pkg::*;
#(
  parameter int AMP_INIT     = 2,
  parameter int FREQ_INIT    = 3,
  parameter int SETTLE_TICKS = 2,
  parameter int GELIJK_MAX   = 4,
  parameter int HALF_BASE    = 4000000,
  parameter int PWM_DIV      = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       slowClk,
  input  logic       aan,
  input  logic       stressLaag,
  input  logic       stressGelijk,
  output logic [2:0] amplitude,
  output logic [2:0] frequentie,
  output logic       motorLinks,
  output logic       motorRechts,
  output logic [1:0] toestand
);

  localparam int SW = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;
  localparam int GW = (GELIJK_MAX > 1) ? $clog2(GELIJK_MAX + 1) : 1;

  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_TICKS);
  localparam logic [GW-1:0] GELIJK_LAST = GW'(GELIJK_MAX - 1);

  toestand_t     state;
  logic          slow_q;
  logic          slow_qq;
  logic          strobe;
  logic          keuze;
  logic          stap;
  logic [GW-1:0] gelijk_cnt;
  logic [SW-1:0] settle_cnt;

  logic       do_step;
  logic       step_dir;
  logic [2:0] sel_val;
  logic [2:0] sel_min;
  logic [2:0] sel_max;
  logic       blocked;
  logic [2:0] stepped;

  assign strobe = slow_q & ~slow_qq;

  // Step decision for the EVAL cycle. A rise in stress (neither flag) reverses
  // the direction before stepping; stressLaag wins over stressGelijk.
  always_comb begin
    do_step  = stressLaag | ~stressGelijk;
    step_dir = stressLaag ? stap : ~stap;
    sel_val  = (keuze == KEUZE_FREQ) ? frequentie : amplitude;
    sel_min  = (keuze == KEUZE_FREQ) ? FREQ_MIN : AMP_MIN;
    sel_max  = (keuze == KEUZE_FREQ) ? FREQ_MAX : AMP_MAX;
    blocked  = step_blocked(sel_val, sel_min, sel_max, step_dir);
    stepped  = (step_dir == STAP_UP) ? (sel_val + 3'd1) : (sel_val - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      slow_q     <= 1'b0;
      slow_qq    <= 1'b0;
      state      <= UIT;
      amplitude  <= 3'(AMP_INIT);
      frequentie <= 3'(FREQ_INIT);
      keuze      <= KEUZE_AMP;
      stap       <= STAP_UP;
      gelijk_cnt <= '0;
      settle_cnt <= SETTLE_LOAD;
    end else begin
      slow_q  <= slowClk;
      slow_qq <= slow_q;

      if (!aan) begin
        state <= UIT;
      end else begin
        case (state)
          UIT: begin
            state      <= WACHT;
            settle_cnt <= SETTLE_LOAD;
          end

          WACHT: begin
            if (strobe) begin
              if (settle_cnt == '0) state <= EVAL;
              else                  settle_cnt <= settle_cnt - SW'(1);
            end
          end

          EVAL: begin
            state <= WACHT;
            if (do_step) begin
              gelijk_cnt <= '0;
              if (blocked) begin
                // At a bound: hold the value and turn around for next time.
                stap <= ~step_dir;
              end else begin
                stap       <= step_dir;
                settle_cnt <= SETTLE_LOAD;
                if (keuze == KEUZE_FREQ) frequentie <= stepped;
                else                     amplitude  <= stepped;
              end
            end else if (gelijk_cnt == GELIJK_LAST) begin
              // Plateau: try the other setting, starting upwards.
              keuze      <= ~keuze;
              gelijk_cnt <= '0;
              stap       <= STAP_UP;
            end else begin
              gelijk_cnt <= gelijk_cnt + GW'(1);
            end
          end

          default: state <= UIT;
        endcase
      end
    end
  end

  assign toestand = state;

  wieg_pwm #(
    .HALF_BASE(HALF_BASE),
    .PWM_DIV  (PWM_DIV)
  ) u_pwm (
    .clk        (clk),
    .reset      (reset),
    .enable     (aan & (state != UIT)),
    .amplitude  (amplitude),
    .frequentie (frequentie),
    .motorLinks (motorLinks),
    .motorRechts(motorRechts)
  );

endmodule

// File: tb/tb_wieg_aansturing.sv
// tb/tb_wieg_aansturing.sv - self-checking bench for wieg_aansturing
module tb_wieg_aansturing;

  localparam int ST = 2;
  localparam int GM = 3;
  localparam int HB = 4;
  localparam int PD = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       slowClk = 1'b0;
  logic       aan = 1'b0;
  logic       stressLaag = 1'b0;
  logic       stressGelijk = 1'b0;
  logic [2:0] amplitude;
  logic [2:0] frequentie;
  logic       motorLinks;
  logic       motorRechts;
  logic [1:0] toestand;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_amp, m_freq, m_keuze, m_stap, m_gel, m_settle;

  wieg_aansturing #(
    .AMP_INIT    (2),
    .FREQ_INIT   (3),
    .SETTLE_TICKS(ST),
    .GELIJK_MAX  (GM),
    .HALF_BASE   (HB),
    .PWM_DIV     (PD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .slowClk     (slowClk),
    .aan         (aan),
    .stressLaag  (stressLaag),
    .stressGelijk(stressGelijk),
    .amplitude   (amplitude),
    .frequentie  (frequentie),
    .motorLinks  (motorLinks),
    .motorRechts (motorRechts),
    .toestand    (toestand)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    m_amp = 2; m_freq = 3; m_keuze = 0; m_stap = 0; m_gel = 0; m_settle = ST;
  endfunction

  function automatic void model_step(input int d);
    int v, lo;
    v  = (m_keuze == 1) ? m_freq : m_amp;
    lo = (m_keuze == 1) ? 0 : 1;
    if ((d == 0 && v == 7) || (d == 1 && v == lo)) begin
      m_stap = 1 - d;
    end else begin
      v = (d == 1) ? v - 1 : v + 1;
      if (m_keuze == 1) m_freq = v; else m_amp = v;
      m_stap = d;
      m_settle = ST;
    end
  endfunction

  function automatic void model_strobe(input bit laag, input bit gel);
    if (m_settle > 0) begin
      m_settle = m_settle - 1;
    end else if (laag) begin
      model_step(m_stap);
      m_gel = 0;
    end else if (gel) begin
      m_gel = m_gel + 1;
      if (m_gel == GM) begin
        m_keuze = 1 - m_keuze;
        m_gel = 0;
        m_stap = 0;
      end
    end else begin
      model_step(1 - m_stap);
      m_gel = 0;
    end
  endfunction

  // One slowClk pulse, checking the state/latency at each edge.
  task automatic tick(input bit laag, input bit gel, output bit evaluated);
    int old_amp, old_freq;
    evaluated = (m_settle == 0);
    old_amp = m_amp;
    old_freq = m_freq;
    @(negedge clk);
    stressLaag = laag; stressGelijk = gel; slowClk = 1'b1;
    @(negedge clk);  // strobe cycle
    checks++;
    if (toestand !== 2'd1) begin
      failures++;
      $display("FAIL tick_strobe_state: got %0d expected 1", toestand);
    end
    @(negedge clk);  // EVAL cycle when settled
    checks++;
    if (toestand !== (evaluated ? 2'd2 : 2'd1)) begin
      failures++;
      $display("FAIL tick_eval_state: got %0d expected %0d", toestand, evaluated ? 2 : 1);
    end
    checks++;
    if (amplitude !== 3'(old_amp) || frequentie !== 3'(old_freq)) begin
      failures++;
      $display("FAIL tick_early_change: got amp=%0d freq=%0d expected amp=%0d freq=%0d",
               amplitude, frequentie, old_amp, old_freq);
    end
    model_strobe(laag, gel);
    @(negedge clk);
    checks++;
    if (amplitude !== 3'(m_amp) || frequentie !== 3'(m_freq) || toestand !== 2'd1) begin
      failures++;
      $display("FAIL tick_result: got amp=%0d freq=%0d state=%0d expected amp=%0d freq=%0d state=1",
               amplitude, frequentie, toestand, m_amp, m_freq);
    end
    slowClk = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Pulse until one strobe is actually evaluated (settle counter at zero).
  task automatic tick_eval(input bit laag, input bit gel);
    bit ev;
    ev = 1'b0;
    for (int i = 0; i <= ST && !ev; i++) tick(laag, gel, ev);
  endtask

  task automatic check_amp(input string name, input int exp);
    checks++;
    if (amplitude !== 3'(exp)) begin
      failures++;
      $display("FAIL %s: amplitude got %0d expected %0d", name, amplitude, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; aan = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (amplitude !== 3'd2 || frequentie !== 3'd3 || motorLinks !== 1'b0 ||
        motorRechts !== 1'b0 || toestand !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: amp=%0d freq=%0d L=%0b R=%0b state=%0d expected 2 3 0 0 0",
               amplitude, frequentie, motorLinks, motorRechts, toestand);
    end
    model_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (toestand !== 2'd1) begin
      failures++;
      $display("FAIL reset_release_state: got %0d expected 1", toestand);
    end
  endtask

  task automatic test_climb();
    tick_eval(1, 0); check_amp("climb_1", 3);
    tick_eval(1, 0); check_amp("climb_2", 4);
    tick_eval(1, 0); check_amp("climb_3", 5);
  endtask

  task automatic test_reverse();
    tick_eval(0, 0); check_amp("reverse_rise", 4);
    tick_eval(1, 0); check_amp("reverse_continue", 3);
  endtask

  task automatic test_clamp();
    tick_eval(0, 0);              // turn back upwards: 4
    repeat (3) tick_eval(1, 0);   // 7
    check_amp("clamp_reach_top", 7);
    tick_eval(1, 0); check_amp("clamp_top_hold", 7);
    tick_eval(1, 0); check_amp("clamp_top_turn", 6);
    repeat (5) tick_eval(1, 0);
    check_amp("clamp_reach_bottom", 1);
    tick_eval(1, 0); check_amp("clamp_bottom_hold", 1);
    tick_eval(1, 0); check_amp("clamp_bottom_turn", 2);
  endtask

  task automatic test_gelijk();
    bit ev;
    repeat (GM) tick_eval(0, 1);
    checks++;
    if (amplitude !== 3'd2 || frequentie !== 3'd3) begin
      failures++;
      $display("FAIL gelijk_no_change: amp=%0d freq=%0d expected 2 3", amplitude, frequentie);
    end
    tick_eval(1, 0);
    checks++;
    if (frequentie !== 3'd4 || amplitude !== 3'd2) begin
      failures++;
      $display("FAIL gelijk_freq_step: amp=%0d freq=%0d expected 2 4", amplitude, frequentie);
    end
    tick(1, 0, ev);
    tick(1, 0, ev);
    checks++;
    if (frequentie !== 3'd4) begin
      failures++;
      $display("FAIL gelijk_settle_ignored: freq=%0d expected 4", frequentie);
    end
    tick(1, 0, ev);
    checks++;
    if (frequentie !== 3'd5) begin
      failures++;
      $display("FAIL gelijk_after_settle: freq=%0d expected 5", frequentie);
    end
  endtask

  task automatic test_random(input int n);
    bit ev;
    for (int i = 0; i < n; i++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ev);
    end
  endtask

  task automatic test_pwm();
    bit l [256];
    bit r [256];
    int both, win_err, flip_err, same_err, h, s;
    both = 0; win_err = 0; flip_err = 0; same_err = 0;
    repeat (80) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      l[i] = motorLinks;
      r[i] = motorRechts;
      if (motorLinks && motorRechts) both++;
      @(negedge clk);
    end
    h = HB * (8 - m_freq);
    for (int t = 0; t <= 248; t++) begin
      s = 0;
      for (int k = 0; k < 8; k++) s += int'(l[t+k] | r[t+k]);
      if (s != m_amp) win_err++;
    end
    for (int t = 0; t + 2 * h < 256; t++) begin
      if ((l[t] | r[t]) && (l[t+h] | r[t+h]) && l[t] == l[t+h]) flip_err++;
      if ((l[t] | r[t]) && (l[t+2*h] | r[t+2*h]) && l[t] != l[t+2*h]) same_err++;
    end
    checks++;
    if (both != 0) begin
      failures++;
      $display("FAIL pwm_both_on: %0d cycles with both motors on, expected 0", both);
    end
    checks++;
    if (win_err != 0) begin
      failures++;
      $display("FAIL pwm_duty: %0d windows with on-count != %0d (amp=%0d freq=%0d)",
               win_err, m_amp, m_amp, m_freq);
    end
    checks++;
    if (flip_err != 0) begin
      failures++;
      $display("FAIL pwm_dir_flip: %0d pairs same side one half-period apart, expected 0 (h=%0d)",
               flip_err, h);
    end
    checks++;
    if (same_err != 0) begin
      failures++;
      $display("FAIL pwm_dir_period: %0d pairs differing one period apart, expected 0 (h=%0d)",
               same_err, h);
    end
  endtask

  task automatic test_aan_off();
    int on_cnt;
    on_cnt = 0;
    @(negedge clk);
    aan = 1'b0;
    @(negedge clk);
    checks++;
    if (toestand !== 2'd0 || motorLinks !== 1'b0 || motorRechts !== 1'b0) begin
      failures++;
      $display("FAIL aan_off_edge: state=%0d L=%0b R=%0b expected 0 0 0",
               toestand, motorLinks, motorRechts);
    end
    repeat (20) begin
      @(negedge clk);
      if (motorLinks || motorRechts) on_cnt++;
    end
    checks++;
    if (on_cnt != 0 || amplitude !== 3'(m_amp) || frequentie !== 3'(m_freq)) begin
      failures++;
      $display("FAIL aan_off_hold: on_cycles=%0d amp=%0d freq=%0d expected 0 %0d %0d",
               on_cnt, amplitude, frequentie, m_amp, m_freq);
    end
    aan = 1'b1;
    m_settle = ST;
    @(negedge clk);
    checks++;
    if (toestand !== 2'd1) begin
      failures++;
      $display("FAIL aan_on_state: got %0d expected 1", toestand);
    end
  endtask

  initial begin
    test_reset();
    test_climb();
    test_reverse();
    test_clamp();
    test_gelijk();
    test_pwm();
    test_aan_off();
    test_random(40);
    test_pwm();
    test_random(30);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
